// File: rtl/multi_issue_queue.sv
// Multi-issue, age-ordered issue queue.
// Entries are kept compacted with index 0 as the oldest. Each cycle the
// oldest ready entries go to the unstalled issue ports. The issued or flushed
// entries are squeezed out, and the accepted enqueue lanes are appended behind
// the survivors.

// Per-operand wakeup matcher. The operand is available if it was already
// available, or if any valid wake bus carries its tag this cycle.
module multi_issue_queue_wake #(
  parameter int TAG_W    = 7,
  parameter int NUM_WAKE = 4
) (
  input  logic [TAG_W-1:0]          tag,
  input  logic                      avail,
  input  logic [NUM_WAKE-1:0]       wake_valid,
  input  logic [NUM_WAKE*TAG_W-1:0] wake_tag,
  output logic                      avail_out
);
  // OR-reduce tag hits across all wake buses
  always_comb begin
    avail_out = avail;
    for (int w = 0; w < NUM_WAKE; w++)
      if (wake_valid[w] && (wake_tag[w*TAG_W +: TAG_W] == tag)) avail_out = 1'b1;
  end
endmodule

module multi_issue_queue #(
  parameter int SIZE      = 8,
  parameter int NUM_IN    = 4,
  parameter int NUM_OUT   = 2,
  parameter int NUM_WAKE  = 4,
  parameter int TAG_W     = 7,
  parameter int SQN_W     = 7,
  parameter int PAYLOAD_W = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         IN_frontEn,
  input  logic [NUM_IN-1:0]            IN_enValid,
  input  logic [NUM_IN*TAG_W-1:0]      IN_enTagA,
  input  logic [NUM_IN*TAG_W-1:0]      IN_enTagB,
  input  logic [NUM_IN-1:0]            IN_enAvailA,
  input  logic [NUM_IN-1:0]            IN_enAvailB,
  input  logic [NUM_IN*SQN_W-1:0]      IN_enSqN,
  input  logic [NUM_IN*PAYLOAD_W-1:0]  IN_enPayload,
  input  logic [NUM_WAKE-1:0]          IN_wakeValid,
  input  logic [NUM_WAKE*TAG_W-1:0]    IN_wakeTag,
  input  logic                         IN_flush,
  input  logic [SQN_W-1:0]             IN_flushSqN,
  input  logic [NUM_OUT-1:0]           IN_issueStall,
  output logic [NUM_OUT-1:0]           OUT_issueValid,
  output logic [NUM_OUT*SQN_W-1:0]     OUT_issueSqN,
  output logic [NUM_OUT*PAYLOAD_W-1:0] OUT_issuePayload,
  output logic                         OUT_full,
  output logic [$clog2(SIZE):0]        OUT_occupancy
);
  localparam int CNT_W = $clog2(SIZE) + 1;
  localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;

  typedef struct packed {
    logic [TAG_W-1:0]     tag_a;
    logic [TAG_W-1:0]     tag_b;
    logic                 avail_a;
    logic                 avail_b;
    logic [SQN_W-1:0]     sqn;
    logic [PAYLOAD_W-1:0] payload;
  } entry_t;

  entry_t            ent_q  [SIZE];
  entry_t            ent_w  [SIZE];   // stored entries with this cycle's wakeups applied
  entry_t            ent_d  [SIZE];
  entry_t            lane_w [NUM_IN]; // enqueue lanes with this cycle's wakeups applied
  logic [CNT_W-1:0]  count_q, count_d;
  logic [SIZE-1:0]   ent_aa, ent_ab, ready, taken;
  logic [NUM_IN-1:0] lane_aa, lane_ab;
  logic              accept;

  logic [NUM_OUT-1:0]   sel_v;
  logic [SQN_W-1:0]     sel_sqn [NUM_OUT];
  logic [PAYLOAD_W-1:0] sel_pl  [NUM_OUT];

  // True if sequence number a is strictly younger than b (wrap-around safe)
  function automatic logic younger(input logic [SQN_W-1:0] a, input logic [SQN_W-1:0] b);
    logic [SQN_W-1:0] d;
    d = a - b;
    return !d[SQN_W-1] && (d != '0);
  endfunction

  for (genvar i = 0; i < SIZE; i++) begin : g_ent_wake
    multi_issue_queue_wake #(.TAG_W(TAG_W), .NUM_WAKE(NUM_WAKE)) u_wa (
      .tag(ent_q[i].tag_a), .avail(ent_q[i].avail_a), .wake_valid(IN_wakeValid),
      .wake_tag(IN_wakeTag), .avail_out(ent_aa[i]));
    multi_issue_queue_wake #(.TAG_W(TAG_W), .NUM_WAKE(NUM_WAKE)) u_wb (
      .tag(ent_q[i].tag_b), .avail(ent_q[i].avail_b), .wake_valid(IN_wakeValid),
      .wake_tag(IN_wakeTag), .avail_out(ent_ab[i]));
  end

  for (genvar l = 0; l < NUM_IN; l++) begin : g_lane_wake
    multi_issue_queue_wake #(.TAG_W(TAG_W), .NUM_WAKE(NUM_WAKE)) u_wa (
      .tag(IN_enTagA[l*TAG_W +: TAG_W]), .avail(IN_enAvailA[l]), .wake_valid(IN_wakeValid),
      .wake_tag(IN_wakeTag), .avail_out(lane_aa[l]));
    multi_issue_queue_wake #(.TAG_W(TAG_W), .NUM_WAKE(NUM_WAKE)) u_wb (
      .tag(IN_enTagB[l*TAG_W +: TAG_W]), .avail(IN_enAvailB[l]), .wake_valid(IN_wakeValid),
      .wake_tag(IN_wakeTag), .avail_out(lane_ab[l]));
  end

  // Fold the wakeup results into the stored entries and the incoming lanes
  always_comb begin
    for (int i = 0; i < SIZE; i++) begin
      ent_w[i]         = ent_q[i];
      ent_w[i].avail_a = ent_aa[i];
      ent_w[i].avail_b = ent_ab[i];
      ready[i]         = (i < int'(count_q)) && ent_aa[i] && ent_ab[i];
    end
    for (int l = 0; l < NUM_IN; l++) begin
      lane_w[l].tag_a   = IN_enTagA[l*TAG_W +: TAG_W];
      lane_w[l].tag_b   = IN_enTagB[l*TAG_W +: TAG_W];
      lane_w[l].avail_a = lane_aa[l];
      lane_w[l].avail_b = lane_ab[l];
      lane_w[l].sqn     = IN_enSqN[l*SQN_W +: SQN_W];
      lane_w[l].payload = IN_enPayload[l*PAYLOAD_W +: PAYLOAD_W];
    end
  end

  // Full check uses the pre-issue count, so it stays conservative when an issue happens in the same cycle
  always_comb begin
    int pc;
    pc = 0;
    for (int l = 0; l < NUM_IN; l++) pc += int'(IN_enValid[l]);
    OUT_full = pc > (SIZE - int'(count_q));
  end

  assign accept        = IN_frontEn && !OUT_full && !IN_flush;
  assign OUT_occupancy = count_q;

  // Each unstalled port, in port order, takes the oldest ready entry not yet claimed
  always_comb begin
    taken = '0;
    sel_v = '0;
    for (int p = 0; p < NUM_OUT; p++) begin
      logic found;
      found      = 1'b0;
      sel_sqn[p] = '0;
      sel_pl[p]  = '0;
      if (!IN_issueStall[p] && !IN_flush) begin
        for (int i = 0; i < SIZE; i++) begin
          if (!found && ready[i] && !taken[i]) begin
            found      = 1'b1;
            taken[i]   = 1'b1;
            sel_v[p]   = 1'b1;
            sel_sqn[p] = ent_q[i].sqn;
            sel_pl[p]  = ent_q[i].payload;
          end
        end
      end
    end
  end

  // Compact the survivors in age order, then append the accepted lanes in lane order
  always_comb begin
    int n;
    n = 0;
    for (int i = 0; i < SIZE; i++) ent_d[i] = ent_q[i];
    for (int i = 0; i < SIZE; i++) begin
      if ((i < int'(count_q)) && !taken[i] &&
          !(IN_flush && younger(ent_q[i].sqn, IN_flushSqN))) begin
        ent_d[n[IDX_W-1:0]] = ent_w[i];
        n++;
      end
    end
    for (int l = 0; l < NUM_IN; l++) begin
      if (accept && IN_enValid[l] && (n < SIZE)) begin
        ent_d[n[IDX_W-1:0]] = lane_w[l];
        n++;
      end
    end
    count_d = CNT_W'(n);
  end

  // Entry payload storage; the entry count alone defines which entries are valid
  always_ff @(posedge clk) begin
    for (int i = 0; i < SIZE; i++) ent_q[i] <= ent_d[i];
  end

  // Count and issue registers. A stalled port holds unless a flush kills a younger uop.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q          <= '0;
      OUT_issueValid   <= '0;
      OUT_issueSqN     <= '0;
      OUT_issuePayload <= '0;
    end else begin
      count_q <= count_d;
      for (int p = 0; p < NUM_OUT; p++) begin
        if (IN_issueStall[p]) begin
          if (IN_flush && younger(OUT_issueSqN[p*SQN_W +: SQN_W], IN_flushSqN))
            OUT_issueValid[p] <= 1'b0;
        end else begin
          OUT_issueValid[p]                        <= sel_v[p];
          OUT_issueSqN[p*SQN_W +: SQN_W]           <= sel_sqn[p];
          OUT_issuePayload[p*PAYLOAD_W +: PAYLOAD_W] <= sel_pl[p];
        end
      end
    end
  end
endmodule

// File: tb/tb_multi_issue_queue.sv
// Directed bench for multi_issue_queue with a scoreboard of expected issues.
module tb_multi_issue_queue;
  localparam int SIZE = 8, NUM_IN = 4, NUM_OUT = 2, NUM_WAKE = 4;
  localparam int TAG_W = 7, SQN_W = 7, PAYLOAD_W = 64;

  logic clk = 1'b0;
  logic rst;
  logic IN_frontEn;
  logic [NUM_IN-1:0] IN_enValid, IN_enAvailA, IN_enAvailB;
  logic [NUM_IN*TAG_W-1:0] IN_enTagA, IN_enTagB;
  logic [NUM_IN*SQN_W-1:0] IN_enSqN;
  logic [NUM_IN*PAYLOAD_W-1:0] IN_enPayload;
  logic [NUM_WAKE-1:0] IN_wakeValid;
  logic [NUM_WAKE*TAG_W-1:0] IN_wakeTag;
  logic IN_flush;
  logic [SQN_W-1:0] IN_flushSqN;
  logic [NUM_OUT-1:0] IN_issueStall;
  logic [NUM_OUT-1:0] OUT_issueValid;
  logic [NUM_OUT*SQN_W-1:0] OUT_issueSqN;
  logic [NUM_OUT*PAYLOAD_W-1:0] OUT_issuePayload;
  logic OUT_full;
  logic [$clog2(SIZE):0] OUT_occupancy;

  multi_issue_queue #(.SIZE(SIZE), .NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT), .NUM_WAKE(NUM_WAKE),
    .TAG_W(TAG_W), .SQN_W(SQN_W), .PAYLOAD_W(PAYLOAD_W)) dut (
    .clk(clk), .rst(rst), .IN_frontEn(IN_frontEn), .IN_enValid(IN_enValid),
    .IN_enTagA(IN_enTagA), .IN_enTagB(IN_enTagB), .IN_enAvailA(IN_enAvailA),
    .IN_enAvailB(IN_enAvailB), .IN_enSqN(IN_enSqN), .IN_enPayload(IN_enPayload),
    .IN_wakeValid(IN_wakeValid), .IN_wakeTag(IN_wakeTag), .IN_flush(IN_flush),
    .IN_flushSqN(IN_flushSqN), .IN_issueStall(IN_issueStall),
    .OUT_issueValid(OUT_issueValid), .OUT_issueSqN(OUT_issueSqN),
    .OUT_issuePayload(OUT_issuePayload), .OUT_full(OUT_full), .OUT_occupancy(OUT_occupancy));

  always #5 clk = ~clk;

  typedef struct { logic [SQN_W-1:0] sqn; logic [PAYLOAD_W-1:0] pl; } exp_t;
  exp_t sb[$];
  int nerr = 0, nchk = 0;

  function automatic logic [PAYLOAD_W-1:0] pl_of(input int sqn);
    return {32'hC0DE_0000, 32'(sqn)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    IN_frontEn = 0; IN_enValid = '0; IN_enTagA = '0; IN_enTagB = '0;
    IN_enAvailA = '0; IN_enAvailB = '0; IN_enSqN = '0; IN_enPayload = '0;
    IN_wakeValid = '0; IN_wakeTag = '0; IN_flush = 0; IN_flushSqN = '0;
    IN_issueStall = '0;
  endtask

  task automatic set_lane(input int l, input int sqn, input int ta, input bit aa,
                          input int tb, input bit ab);
    IN_frontEn = 1;
    IN_enValid[l] = 1'b1;
    IN_enTagA[l*TAG_W +: TAG_W] = TAG_W'(ta);
    IN_enTagB[l*TAG_W +: TAG_W] = TAG_W'(tb);
    IN_enAvailA[l] = aa;
    IN_enAvailB[l] = ab;
    IN_enSqN[l*SQN_W +: SQN_W] = SQN_W'(sqn);
    IN_enPayload[l*PAYLOAD_W +: PAYLOAD_W] = pl_of(sqn);
  endtask

  task automatic push(input int sqn);
    exp_t e;
    e.sqn = SQN_W'(sqn);
    e.pl  = pl_of(sqn);
    sb.push_back(e);
  endtask

  // Compare issue outputs against the scoreboard, oldest expectation first
  task automatic chk_out(input string tag, input logic [1:0] ev);
    exp_t e;
    chk({tag, "_valid"}, 64'(OUT_issueValid), 64'(ev));
    for (int p = 0; p < NUM_OUT; p++) begin
      if (ev[p]) begin
        if (sb.size() == 0) begin
          nchk++; nerr++;
          $error("FAIL %s_sb: observed=empty expected=entry", tag);
        end else begin
          e = sb.pop_front();
          chk({tag, "_sqn"}, 64'(OUT_issueSqN[p*SQN_W +: SQN_W]), 64'(e.sqn));
          chk({tag, "_pl"}, OUT_issuePayload[p*PAYLOAD_W +: PAYLOAD_W], e.pl);
        end
      end
    end
  endtask

  function automatic logic [SQN_W-1:0] osqn(input int p);
    return OUT_issueSqN[p*SQN_W +: SQN_W];
  endfunction

  initial begin
    clear_in();
    rst = 1;
    tick(); tick();
    rst = 0;
    chk("rst_occ", 64'(OUT_occupancy), 0);
    chk("rst_valid", 64'(OUT_issueValid), 0);
    chk("rst_sqn", 64'(OUT_issueSqN), 0);
    chk("rst_pl", OUT_issuePayload[63:0], 0);
    chk("rst_full", 64'(OUT_full), 0);

    // Four ready lanes issue two per cycle in age order
    for (int l = 0; l < 4; l++) begin set_lane(l, l, 0, 1, 0, 1); push(l); end
    tick(); clear_in();
    chk("t1_occ4", 64'(OUT_occupancy), 4);
    chk_out("t1_c0", 2'b00);
    tick();
    chk("t1_occ2", 64'(OUT_occupancy), 2);
    chk_out("t1_c1", 2'b11);
    tick();
    chk("t1_occ0", 64'(OUT_occupancy), 0);
    chk_out("t1_c2", 2'b11);
    tick();
    chk_out("t1_c3", 2'b00);

    // Wakeup of a stored operand: issue exactly one cycle after the wake
    set_lane(0, 10, 5, 0, 0, 1); push(10);
    tick(); clear_in();
    chk_out("t2_c0", 2'b00);
    tick();
    chk_out("t2_c1", 2'b00);
    IN_wakeValid = 4'b0100; IN_wakeTag[2*TAG_W +: TAG_W] = 7'd5;
    tick(); clear_in();
    chk_out("t2_wake", 2'b01);
    tick();
    chk_out("t2_after", 2'b00);

    // Wakeup that arrives in the same cycle as the enqueue
    set_lane(0, 11, 0, 1, 9, 0); push(11);
    IN_wakeValid = 4'b0001; IN_wakeTag[TAG_W-1:0] = 7'd9;
    tick(); clear_in();
    chk_out("t3_c0", 2'b00);
    tick();
    chk_out("t3_c1", 2'b01);
    chk("t3_occ", 64'(OUT_occupancy), 0);

    // Fill to 8 entries, then check full boundaries
    for (int l = 0; l < 4; l++) set_lane(l, 20 + l, 20, 0, 0, 1);
    tick(); clear_in();
    for (int l = 0; l < 4; l++) set_lane(l, 24 + l, 20, 0, 0, 1);
    #1 chk("t4_full_edge", 64'(OUT_full), 0);
    tick(); clear_in();
    chk("t4_occ8", 64'(OUT_occupancy), 8);
    #1 chk("t4_full_idle", 64'(OUT_full), 0);
    set_lane(0, 28, 0, 1, 0, 1);
    #1 chk("t4_full", 64'(OUT_full), 1);
    tick(); clear_in();
    chk("t4_occ_hold", 64'(OUT_occupancy), 8);
    IN_flush = 1; IN_flushSqN = 7'd19;
    tick(); clear_in();
    chk("t4_flush_all", 64'(OUT_occupancy), 0);
    chk_out("t4_none", 2'b00);

    // Flush across the sequence-number wrap; no issue or enqueue in the flush cycle
    for (int l = 0; l < 4; l++) set_lane(l, (125 + l) % 128, 20, 0, 0, 1);
    tick(); clear_in();
    set_lane(0, 1, 20, 0, 0, 1);
    tick(); clear_in();
    chk("t5_occ5", 64'(OUT_occupancy), 5);
    set_lane(0, 2, 0, 1, 0, 1);
    IN_flush = 1; IN_flushSqN = 7'd127;
    IN_wakeValid = 4'b1000; IN_wakeTag[3*TAG_W +: TAG_W] = 7'd20;
    push(125); push(126); push(127);
    tick(); clear_in();
    chk("t5_occ3", 64'(OUT_occupancy), 3);
    chk_out("t5_flushcyc", 2'b00);
    tick();
    chk_out("t5_i0", 2'b11);
    chk("t5_occ1", 64'(OUT_occupancy), 1);
    tick();
    chk_out("t5_i1", 2'b01);
    chk("t5_occ0", 64'(OUT_occupancy), 0);

    // Per-port stall: port 0 holds while port 1 keeps issuing
    for (int l = 0; l < 4; l++) set_lane(l, 40 + l, 0, 1, 0, 1);
    tick(); clear_in();
    tick();
    chk("t6_v", 64'(OUT_issueValid), 2'b11);
    chk("t6_p0", 64'(osqn(0)), 40);
    chk("t6_p1", 64'(osqn(1)), 41);
    IN_issueStall = 2'b01;
    tick();
    chk("t6_stall_v", 64'(OUT_issueValid), 2'b11);
    chk("t6_stall_p0", 64'(osqn(0)), 40);
    chk("t6_stall_pl0", OUT_issuePayload[63:0], pl_of(40));
    chk("t6_stall_p1", 64'(osqn(1)), 42);
    chk("t6_stall_occ", 64'(OUT_occupancy), 1);
    IN_issueStall = 2'b00;
    tick();
    chk("t6_rel_v", 64'(OUT_issueValid), 2'b01);
    chk("t6_rel_p0", 64'(osqn(0)), 43);
    chk("t6_rel_occ", 64'(OUT_occupancy), 0);
    IN_issueStall = 2'b01; IN_flush = 1; IN_flushSqN = 7'd42;
    tick(); clear_in();
    chk("t6_flush_held", 64'(OUT_issueValid), 2'b00);

    // Reset wins over a simultaneous enqueue and drops in-flight issues
    for (int l = 0; l < 4; l++) set_lane(l, 50 + l, 0, 1, 0, 1);
    tick(); clear_in();
    for (int l = 0; l < 3; l++) set_lane(l, 60 + l, 30, 0, 0, 1);
    tick(); clear_in();
    chk("t7_occ5", 64'(OUT_occupancy), 5);
    chk("t7_v", 64'(OUT_issueValid), 2'b11);
    rst = 1;
    for (int l = 0; l < 4; l++) set_lane(l, 70 + l, 0, 1, 0, 1);
    tick(); clear_in();
    rst = 0;
    chk("t7_rst_occ", 64'(OUT_occupancy), 0);
    chk("t7_rst_v", 64'(OUT_issueValid), 0);
    chk("t7_rst_sqn", 64'(OUT_issueSqN), 0);
    tick();
    chk("t7_post_v", 64'(OUT_issueValid), 0);
    chk("sb_drained", 64'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/multi_issue_queue.md
MULTI_ISSUE_QUEUE -- requirements
Module: multi_issue_queue

Interface
REQ-001 SHALL have parameter SIZE, 8, number of entries.
REQ-002 SHALL have parameter NUM_IN, 4, enqueue lanes.
REQ-003 SHALL have parameter NUM_OUT, 2, issue ports.
REQ-004 SHALL have parameter NUM_WAKE, 4, wakeup buses.
REQ-005 SHALL have parameter TAG_W, 7, physical tag width.
REQ-006 SHALL have parameter SQN_W, 7, sequence number width.
REQ-007 SHALL have parameter PAYLOAD_W, 64, opaque uop payload width.
REQ-008 SHALL have port clk  in  1  clock; all state updates on rising edge.
REQ-009 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-010 SHALL have port IN_frontEn  in  1  enqueue enable.
REQ-011 SHALL have port IN_enValid  in  NUM_IN  per-lane enqueue valid.
REQ-012 SHALL have port IN_enTagA / IN_enTagB  in  NUM_IN*TAG_W  source operand tags.
REQ-013 SHALL have port IN_enAvailA / IN_enAvailB  in  NUM_IN  operand already available.
REQ-014 SHALL have port IN_enSqN  in  NUM_IN*SQN_W  program-order sequence number.
REQ-015 SHALL have port IN_enPayload  in  NUM_IN*PAYLOAD_W  uop payload.
REQ-016 SHALL have port IN_wakeValid  in  NUM_WAKE; IN_wakeTag  in  NUM_WAKE*TAG_W  result broadcast.
REQ-017 SHALL have port IN_flush  in  1; IN_flushSqN  in  SQN_W  mispredict flush.
REQ-018 SHALL have port IN_issueStall  in  NUM_OUT  per-port downstream stall.
REQ-019 SHALL have port OUT_issueValid  out  NUM_OUT; OUT_issueSqN  out  NUM_OUT*SQN_W; OUT_issuePayload  out  NUM_OUT*PAYLOAD_W  registered issue.
REQ-020 SHALL have port OUT_full  out  1 and OUT_occupancy  out  $clog2(SIZE)+1.

Function
REQ-021 Entries SHALL be kept compacted and age-ordered: index 0 oldest, valid indices 0..occupancy-1.
REQ-022 Entry operand A/B SHALL become available when a valid wake tag equals its tag; the match SHALL be usable for selection in the same cycle.
REQ-023 Enqueued lanes SHALL also be matched against same-cycle wake buses before storage.
REQ-024 An entry SHALL be ready when both operands are available (stored or same-cycle wake).
REQ-025 OUT_full SHALL be combinational: popcount(IN_enValid) > SIZE - OUT_occupancy.
REQ-026 When IN_frontEn and !OUT_full and !IN_flush, all valid lanes SHALL be appended in ascending lane order after compaction; when OUT_full, no lane SHALL be accepted (all-or-nothing).
REQ-027 Each cycle, ports with IN_issueStall=0 SHALL be loaded, in ascending port index, with the oldest ready entries not yet selected; surplus free ports SHALL load OUT_issueValid=0.
REQ-028 A stalled port SHALL hold its valid, sqN and payload unchanged and SHALL receive no entry.
REQ-029 Issued entries SHALL be removed and remaining entries shifted down preserving age order in the same cycle; issue latency from ready to OUT_issueValid SHALL be 1 cycle.
REQ-030 On IN_flush, every entry and every output register (stalled or not) with $signed(sqN - IN_flushSqN) > 0 SHALL be invalidated and survivors compacted; no issue and no enqueue SHALL occur that cycle.
REQ-031 Sequence comparison SHALL be modular signed difference of width SQN_W (wrap-around safe).
REQ-032 OUT_occupancy SHALL equal the registered entry count after each update, never exceeding SIZE.
REQ-033 Simultaneous issue and enqueue SHALL be allowed; OUT_full SHALL use pre-issue occupancy (conservative).

Reset
REQ-034 On rst, occupancy SHALL be 0, OUT_issueValid all 0, OUT_issueSqN and OUT_issuePayload 0, all entry valid state cleared.
REQ-035 rst SHALL take priority over flush, enqueue and issue; in-flight outputs SHALL be dropped.

Verification
REQ-036 Enqueue 4 lanes, all avail=1, no stall -> next cycle ports 0,1 issue sqN 0,1; following cycle sqN 2,3; occupancy 4->2->0.
REQ-037 Enqueue entry tagA=5 avail=0; wake tag 5 two cycles later -> OUT_issueValid[0]=1 exactly one cycle after the wake.
REQ-038 Fill 8 entries; IN_enValid=0001 -> OUT_full=1, entry not stored, occupancy stays 8.
REQ-039 Entries sqN 125,126,127,0,1; flush with IN_flushSqN=127 -> entries 0,1 removed, occupancy 3, no issue that cycle.
REQ-040 IN_issueStall=01 with 3 ready entries -> port 0 holds value, port 1 takes oldest ready; stall released -> port 0 takes next oldest.
REQ-041 Assert rst while occupancy 5 and both ports valid -> next cycle occupancy 0, OUT_issueValid=00.
